// File: rtl/layer_align_mux.sv
// Delays each pixel layer and the sync bundle through circular buffers so that all layers line up
// with a common sync delay. Then it picks one pixel by index or by colour-key priority and registers it.
module layer_align_mux #(
  parameter int                NUM_LAYERS = 4,
  parameter int                PIX_W      = 24,
  parameter int                SYNC_W     = 3,
  parameter int                MAX_DELAY  = 64,
  parameter int                DLY_W      = $clog2(MAX_DELAY) + 1,
  parameter logic [SYNC_W-1:0] SYNC_IDLE  = 3'b000
) (
  input  logic                          clk_in,
  input  logic                          rst_in_n,
  input  logic [NUM_LAYERS*PIX_W-1:0]   layer_pix_in,
  input  logic [NUM_LAYERS*DLY_W-1:0]   layer_lat_in,
  input  logic                          cfg_load_in,
  input  logic [SYNC_W-1:0]             sync_in,
  input  logic                          mode_in,
  input  logic [$clog2(NUM_LAYERS)-1:0] sel_in,
  input  logic [PIX_W-1:0]              key_in,
  output logic [PIX_W-1:0]              pix_out,
  output logic [SYNC_W-1:0]             sync_out,
  output logic                          busy_out,
  output logic [1:0]                    state_dbg_out
);

  localparam int               ADDR_W  = $clog2(MAX_DELAY);
  localparam int               SEL_W   = $clog2(NUM_LAYERS);
  localparam logic [DLY_W-1:0] LAT_MAX = DLY_W'(MAX_DELAY - 1);
  localparam logic [DLY_W-1:0] ONE     = DLY_W'(1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    CALC  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DLY_W-1:0]  lat_q [NUM_LAYERS];
  logic [DLY_W-1:0]  lat_d [NUM_LAYERS];
  logic [DLY_W-1:0]  dmax_q, dmax_d, lat_max_c;
  logic [DLY_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [ADDR_W-1:0] wp_q;
  logic [PIX_W-1:0]  pix_mem [NUM_LAYERS][MAX_DELAY];
  logic [SYNC_W-1:0] sync_mem [MAX_DELAY];
  logic [PIX_W-1:0]  aligned [NUM_LAYERS];
  logic [PIX_W-1:0]  sel_tab [2**SEL_W];
  logic [SYNC_W-1:0] sync_al;
  logic [ADDR_W-1:0] sync_rd;
  logic [PIX_W-1:0]  mux_pix;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [SYNC_W-1:0] sync_q, sync_d;

  always_comb begin
    lat_max_c = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      lat_d[i] = lat_q[i];
      if (cfg_load_in) begin
        lat_d[i] = (layer_lat_in[i*DLY_W +: DLY_W] > LAT_MAX) ? LAT_MAX
                                                             : layer_lat_in[i*DLY_W +: DLY_W];
      end
      if (lat_q[i] > lat_max_c) lat_max_c = lat_q[i];
    end
  end

  // A load in any state restarts CALC, so the most recent configuration always wins.
  always_comb begin
    state_d     = state_q;
    dmax_d      = dmax_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      RUN:   ;
      CALC: begin
        dmax_d      = lat_max_c;
        flush_cnt_d = lat_max_c + ONE;
        state_d     = FLUSH;
      end
      FLUSH: begin
        flush_cnt_d = flush_cnt_q - ONE;
        if (flush_cnt_q == ONE) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (cfg_load_in) state_d = CALC;
  end

  always_ff @(posedge clk_in) begin
    sync_mem[wp_q] <= sync_in;
    for (int i = 0; i < NUM_LAYERS; i++) pix_mem[i][wp_q] <= layer_pix_in[i*PIX_W +: PIX_W];
  end

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
    logic [DLY_W-1:0]  dly;
    logic [ADDR_W-1:0] rd_addr;
    assign dly        = dmax_q - lat_q[g];
    assign rd_addr    = wp_q - dly[ADDR_W-1:0];
    assign aligned[g] = (dly == '0) ? layer_pix_in[g*PIX_W +: PIX_W] : pix_mem[g][rd_addr];
  end

  assign sync_rd = wp_q - dmax_q[ADDR_W-1:0];
  assign sync_al = (dmax_q == '0) ? sync_in : sync_mem[sync_rd];

  // Indices past the last layer select a zero pixel.
  for (genvar g = 0; g < 2**SEL_W; g++) begin : g_sel
    if (g < NUM_LAYERS) begin : g_real
      assign sel_tab[g] = aligned[g];
    end else begin : g_zero
      assign sel_tab[g] = '0;
    end
  end

  always_comb begin
    mux_pix = sel_tab[sel_in];
    if (mode_in) begin
      mux_pix = aligned[NUM_LAYERS-1];
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
        if (aligned[i] != key_in) mux_pix = aligned[i];
      end
    end
  end

  // The output is gated on the next state, so the first RUN cycle already carries aligned data.
  always_comb begin
    pix_d  = '0;
    sync_d = SYNC_IDLE;
    if (state_d == RUN) begin
      pix_d  = mux_pix;
      sync_d = sync_al;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q     <= RUN;
      dmax_q      <= '0;
      flush_cnt_q <= '0;
      wp_q        <= '0;
      pix_q       <= '0;
      sync_q      <= SYNC_IDLE;
      for (int i = 0; i < NUM_LAYERS; i++) lat_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      dmax_q      <= dmax_d;
      flush_cnt_q <= flush_cnt_d;
      wp_q        <= wp_q + 1'b1;
      pix_q       <= pix_d;
      sync_q      <= sync_d;
      for (int i = 0; i < NUM_LAYERS; i++) lat_q[i] <= lat_d[i];
    end
  end

  assign pix_out       = pix_q;
  assign sync_out      = sync_q;
  assign busy_out      = (state_q != RUN);
  assign state_dbg_out = state_q;

endmodule

// File: tb/tb_layer_align_mux.sv
// Directed bench for layer_align_mux: reset, default alignment, colour-key priority,
// mixed latencies, reconfiguration, clamping, out-of-range select and reset during flush.
module tb_layer_align_mux;

  localparam int              NL = 4;
  localparam int              PW = 24;
  localparam int              SW = 3;
  localparam int              DW = 7;
  localparam logic [SW-1:0]   IDLE = 3'b000;
  localparam logic [PW-1:0]   KEY  = 24'hFF00FF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [NL*PW-1:0] layer_pix;
  logic [NL*DW-1:0] layer_lat;
  logic             cfg_load;
  logic [SW-1:0]    sync_i;
  logic             mode;
  logic [1:0]       sel;
  logic [PW-1:0]    key;
  logic [PW-1:0]    pix_o;
  logic [SW-1:0]    sync_o;
  logic             busy_o;
  logic [1:0]       state_o;

  logic [3*PW-1:0]  layer_pix3;
  logic [3*DW-1:0]  layer_lat3;
  logic             cfg_load3;
  logic             mode3;
  logic [1:0]       sel3;
  logic [PW-1:0]    key3;
  logic [PW-1:0]    pix3_o;
  logic [SW-1:0]    sync3_o;
  logic             busy3_o;
  logic [1:0]       state3_o;

  int total = 0;
  int bad   = 0;
  int t     = 100;
  int lat_model [NL];
  bit ramp_en;
  int n;

  layer_align_mux #(.NUM_LAYERS(NL)) u_dut (
    .clk_in(clk), .rst_in_n(rst_n), .layer_pix_in(layer_pix), .layer_lat_in(layer_lat),
    .cfg_load_in(cfg_load), .sync_in(sync_i), .mode_in(mode), .sel_in(sel), .key_in(key),
    .pix_out(pix_o), .sync_out(sync_o), .busy_out(busy_o), .state_dbg_out(state_o)
  );

  layer_align_mux #(.NUM_LAYERS(3)) u_dut3 (
    .clk_in(clk), .rst_in_n(rst_n), .layer_pix_in(layer_pix3), .layer_lat_in(layer_lat3),
    .cfg_load_in(cfg_load3), .sync_in(sync_i), .mode_in(mode3), .sel_in(sel3), .key_in(key3),
    .pix_out(pix3_o), .sync_out(sync3_o), .busy_out(busy3_o), .state_dbg_out(state3_o)
  );

  function automatic logic [PW-1:0] exp_pix(input int s, input int x);
    return {8'(s), 16'(x)};
  endfunction

  function automatic logic [SW-1:0] sync_fn(input int x);
    logic [31:0] v;
    v = x;
    return v[2:0] ^ v[5:3];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    sync_i = sync_fn(t);
    if (ramp_en) begin
      for (int i = 0; i < NL; i++) layer_pix[i*PW +: PW] = exp_pix(i, t - lat_model[i]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
    drive();
  endtask

  task automatic load(input int l0, input int l1, input int l2, input int l3, input int eff3);
    layer_lat    = {7'(l3), 7'(l2), 7'(l1), 7'(l0)};
    lat_model[0] = l0;
    lat_model[1] = l1;
    lat_model[2] = l2;
    lat_model[3] = eff3;
    cfg_load     = 1'b1;
    drive();
    tick();
    cfg_load = 1'b0;
  endtask

  // Counts busy cycles, checking idle outputs; optionally reloads layer 3 at busy cycle reload_at.
  task automatic flush_count(input int reload_at, input int rl3, output int cnt);
    cnt = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy_o) break;
      cnt++;
      check("flush_pix", 32'(pix_o), 32'(0));
      check("flush_sync", 32'(sync_o), 32'(IDLE));
      cfg_load = (cnt == reload_at);
      if (cnt == reload_at) begin
        layer_lat    = {7'(rl3), 21'(0)};
        lat_model[3] = rl3;
      end
      tick();
    end
  endtask

  // Entered at the negedge of the first RUN cycle with sel=0 held during the previous cycle.
  task automatic check_aligned(input int d);
    check("al_sync", 32'(sync_o), 32'(sync_fn(t - 1 - d)));
    check("al_pix0", 32'(pix_o), 32'(exp_pix(0, t - 1 - d)));
    for (int s = 1; s < NL; s++) begin
      sel = 2'(s);
      tick();
      @(negedge clk);
      check("al_pix", 32'(pix_o), 32'(exp_pix(s, t - 1 - d)));
      check("al_sync", 32'(sync_o), 32'(sync_fn(t - 1 - d)));
    end
    sel = 2'd0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b1;
    cfg_load   = 1'b0;
    mode       = 1'b0;
    sel        = 2'd0;
    key        = '0;
    layer_lat  = '0;
    layer_pix  = '0;
    ramp_en    = 1'b1;
    for (int i = 0; i < NL; i++) lat_model[i] = 0;
    layer_pix3 = '0;
    layer_lat3 = '0;
    cfg_load3  = 1'b0;
    mode3      = 1'b0;
    sel3       = 2'd0;
    key3       = '0;
    drive();
    #2 rst_n = 1'b0;
    #1;
    check("rst_pix", 32'(pix_o), 32'(0));
    check("rst_sync", 32'(sync_o), 32'(IDLE));
    check("rst_busy", 32'(busy_o), 32'(0));
    check("rst_state", 32'(state_o), 32'(0));
    repeat (3) tick();
    rst_n = 1'b1;

    // Default configuration: latency 1, busy never rises.
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      check("dflt_sync", 32'(sync_o), 32'(sync_fn(t - 1)));
      check("dflt_pix", 32'(pix_o), 32'(exp_pix(0, t - 1)));
      check("dflt_busy", 32'(busy_o), 32'(0));
    end
    for (int s = 0; s < NL; s++) begin
      sel = 2'(s);
      tick();
      @(negedge clk);
      check("dflt_sel", 32'(pix_o), 32'(exp_pix(s, t - 1)));
    end
    sel = 2'd0;

    // Three-layer instance: index 3 is out of range.
    layer_pix3 = {24'hCCCCCC, 24'hBBBBBB, 24'hAAAAAA};
    sel3 = 2'd2;
    tick();
    @(negedge clk);
    check("sel3_2", 32'(pix3_o), 32'h00CCCCCC);
    sel3 = 2'd3;
    tick();
    @(negedge clk);
    check("sel3_oor", 32'(pix3_o), 32'(0));
    sel3 = 2'd0;
    tick();
    @(negedge clk);
    check("sel3_0", 32'(pix3_o), 32'h00AAAAAA);

    // Colour-key priority with static layers.
    ramp_en   = 1'b0;
    mode      = 1'b1;
    key       = KEY;
    layer_pix = {24'h777777, 24'h555555, 24'h123456, KEY};
    tick();
    @(negedge clk);
    check("key_first", 32'(pix_o), 32'h00123456);
    layer_pix = {KEY, KEY, KEY, KEY};
    sel = 2'd2;
    tick();
    @(negedge clk);
    check("key_all", 32'(pix_o), 32'(KEY));
    layer_pix = {24'h111111, 24'hABCDEF, KEY, KEY};
    sel = 2'd1;
    tick();
    @(negedge clk);
    check("key_l2", 32'(pix_o), 32'h00ABCDEF);
    layer_pix = {24'h111111, 24'hABCDEF, KEY, 24'h000001};
    sel = 2'd3;
    tick();
    @(negedge clk);
    check("key_l0", 32'(pix_o), 32'h00000001);
    mode = 1'b0;
    sel  = 2'd2;
    tick();
    @(negedge clk);
    check("idx_static", 32'(pix_o), 32'h00ABCDEF);
    sel     = 2'd0;
    ramp_en = 1'b1;
    drive();
    tick();

    // Mixed latencies {0,3,7,47}: D=47, busy for 49 cycles.
    load(0, 3, 7, 47, 47);
    flush_count(0, 0, n);
    check("mixed_busy_len", 32'(n), 32'(49));
    check_aligned(47);

    // Reload 5 cycles after the first load; busy stays high until 22 cycles after the reload.
    load(0, 0, 0, 10, 10);
    flush_count(5, 20, n);
    check("reload_busy_len", 32'(n), 32'(27));
    check_aligned(20);

    // Field 100 clamps to 63: busy for 65 cycles, sync latency 64.
    load(0, 0, 0, 100, 63);
    flush_count(0, 0, n);
    check("clamp_busy_len", 32'(n), 32'(65));
    check_aligned(63);

    // Reset in the middle of a flush.
    load(0, 0, 0, 47, 47);
    repeat (5) tick();
    @(negedge clk);
    check("pre_rst_busy", 32'(busy_o), 32'(1));
    rst_n = 1'b0;
    #1;
    check("flush_rst_busy", 32'(busy_o), 32'(0));
    check("flush_rst_state", 32'(state_o), 32'(0));
    check("flush_rst_pix", 32'(pix_o), 32'(0));
    check("flush_rst_sync", 32'(sync_o), 32'(IDLE));
    for (int i = 0; i < NL; i++) lat_model[i] = 0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sel = 2'(k + 1);
      tick();
      @(negedge clk);
      check("post_rst_pix", 32'(pix_o), 32'(exp_pix(k + 1, t - 1)));
      check("post_rst_sync", 32'(sync_o), 32'(sync_fn(t - 1)));
      check("post_rst_busy", 32'(busy_o), 32'(0));
    end

    // Asynchronous reset while a nonzero pixel is on the output.
    rst_n = 1'b0;
    #1;
    check("run_rst_pix", 32'(pix_o), 32'(0));
    check("run_rst_sync", 32'(sync_o), 32'(IDLE));
    tick();
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
